tone_sequencer: RTL

//  Upstream feeder for the tone generator: plays a CPU-loaded melody table by issuing

---
 rtl/tone_seq_pkg.sv | 26 ++
 rtl/tone_sequencer_tick.sv | 30 +++
 rtl/tone_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer.
// Holds the FSM states, register map and note-table entry layout.
package tone_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PLAY,
      GAP,
      NEXT,
      STOP
   } state_e;

   localparam int CTRL_START = 0;
   localparam int CTRL_LOOP  = 1;
   localparam int CTRL_STOP  = 2;

   localparam int REG_CTRL = 0;
   localparam int REG_LEN  = 1;

   typedef struct packed {
      logic [15:0] freq_hz;
      logic [15:0] dur_ms;
   } note_t;

endpackage

// File: rtl/tone_sequencer_tick.sv
// Duration prescaler: one tick on the last cycle of every P-cycle period.
// The clearing cycle counts as the first cycle of a fresh period.
module tick_gen #(
   parameter int P = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = $clog2(P);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= CW'(1);
      end else if (cnt_q == CW'(P - 1)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tick_o = !clr_i && (cnt_q == CW'(P - 1));

endmodule

// File: rtl/tone_sequencer.sv
// Melody player: walks a CPU-loaded note table and feeds frequency
// writes to the tone generator, one pulse per note, gap or stop.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int FCLK    = 50_000_000,
   parameter int TICK_HZ = 1000,
   parameter int DEPTH   = 16,
   parameter int GAP_MS  = 20,
   localparam int AW     = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] address,
   input  logic          write,
   input  logic [31:0]   writedata,
   input  logic          read,
   output logic [31:0]   readdata,
   output logic [31:0]   tone_writedata,
   output logic          tone_write,
   output logic          busy,
   output logic          done
);

   localparam int P  = FCLK / TICK_HZ;
   localparam int IW = AW - 1;

   state_e        state_q;
   logic [IW-1:0] idx_q;
   logic [AW-1:0] len_q;
   logic          loop_q;
   logic          sticky_q;
   logic          abort_q;
   logic [15:0]   dur_q;
   logic [15:0]   ms_q;
   logic [15:0]   freq_q;
   logic          pulse_q;
   logic          done_q;
   note_t         tbl_q [DEPTH];

   logic tick;
   logic unused_read;

   assign unused_read = read;

   tick_gen #(
      .P(P)
   ) u_tick (
      .clk_i (clk),
      .rst_ni(reset),
      .clr_i (pulse_q),
      .tick_o(tick)
   );

   logic tbl_wr, ctrl_wr, len_wr;
   logic start_req, stop_req;

   assign tbl_wr    = write && address[AW-1];
   assign ctrl_wr   = write && !address[AW-1]
                      && (address[IW-1:0] == IW'(REG_CTRL));
   assign len_wr    = write && !address[AW-1]
                      && (address[IW-1:0] == IW'(REG_LEN));
   assign start_req = ctrl_wr && writedata[CTRL_START];
   assign stop_req  = ctrl_wr && writedata[CTRL_STOP];

   always_ff @(posedge clk) begin
      if (tbl_wr) begin
         tbl_q[address[IW-1:0]] <= writedata;
      end
   end

   // Zero-duration entries are skipped within the same cycle, so the
   // pulse spacing is unaffected by how many of them sit in between.
   logic [IW-1:0] base, s_idx;
   logic          incl, lp_sel, s_found, s_stop;

   always_comb begin
      incl    = (state_q == IDLE);
      base    = incl ? '0 : idx_q;
      lp_sel  = incl ? writedata[CTRL_LOOP] : loop_q;
      s_idx   = base;
      s_stop  = 1'b0;
      s_found = incl && (tbl_q[base].dur_ms != '0);
      for (int k = 0; k < DEPTH; k++) begin
         if (!s_found && !s_stop) begin
            if ({1'b0, s_idx} == len_q - AW'(1)) begin
               if (lp_sel) s_idx = '0;
               else        s_stop = 1'b1;
            end else begin
               s_idx = s_idx + IW'(1);
            end
            if (!s_stop && tbl_q[s_idx].dur_ms != '0) s_found = 1'b1;
         end
      end
   end

   logic [15:0] lim;
   logic        seg_end, abort, start_ok, adv, to_gap;

   always_comb begin
      lim      = (state_q == GAP) ? 16'(GAP_MS) : dur_q;
      seg_end  = tick && (ms_q + 16'd1 == lim);
      abort    = stop_req && (state_q != IDLE) && (state_q != STOP);
      start_ok = (state_q == IDLE) && start_req && !stop_req
                 && (len_q != '0);
      to_gap   = !abort && (GAP_MS != 0)
                 && (state_q == PLAY) && seg_end;
      adv      = !abort && (start_ok
                 || ((state_q == PLAY) && seg_end && (GAP_MS == 0))
                 || ((state_q == GAP) && seg_end)
                 || (state_q == NEXT));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         loop_q   <= 1'b0;
         sticky_q <= 1'b0;
         abort_q  <= 1'b0;
         dur_q    <= '0;
         ms_q     <= '0;
         freq_q   <= '0;
         pulse_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
         if (len_wr && state_q == IDLE) begin
            len_q <= writedata[AW-1:0];
         end
         if (abort) begin
            // A pulse is already on the bus: defer the silence one cycle.
            if (pulse_q) begin
               state_q <= STOP;
               abort_q <= 1'b1;
            end else begin
               state_q <= IDLE;
               pulse_q <= 1'b1;
               freq_q  <= '0;
            end
         end else if (adv) begin
            if (start_ok) begin
               loop_q   <= writedata[CTRL_LOOP];
               sticky_q <= 1'b0;
            end
            idx_q <= s_idx;
            if (s_stop) begin
               state_q  <= STOP;
               pulse_q  <= 1'b1;
               freq_q   <= '0;
               done_q   <= 1'b1;
               sticky_q <= 1'b1;
            end else if (s_found) begin
               state_q <= LOAD;
               pulse_q <= 1'b1;
               freq_q  <= tbl_q[s_idx].freq_hz;
               dur_q   <= tbl_q[s_idx].dur_ms;
               ms_q    <= '0;
            end else begin
               state_q <= NEXT;
            end
         end else if (to_gap) begin
            state_q <= GAP;
            pulse_q <= 1'b1;
            freq_q  <= '0;
            ms_q    <= '0;
         end else begin
            unique case (state_q)
               LOAD: state_q <= PLAY;
               PLAY, GAP: begin
                  if (tick) ms_q <= ms_q + 16'd1;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (abort_q) begin
                     pulse_q <= 1'b1;
                     freq_q  <= '0;
                     abort_q <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign tone_write     = pulse_q;
   assign tone_writedata = {16'b0, freq_q};
   assign done           = done_q;
   assign busy           = (state_q != IDLE);
   assign readdata       = {16'b0, 8'(idx_q), 6'b0, sticky_q, busy};

endmodule
